// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the byte-serial memory arbiter: FSM state codes,
//   access width codes, the bytes-per-word constant and small helpers used by
//   both the arbiter and its load extension sub-module.
package mem_arbiter_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [1:0] WIDTH_BYTE = 2'b00;
   localparam logic [1:0] WIDTH_HALF = 2'b01;
   localparam logic [1:0] WIDTH_WORD = 2'b10;

   localparam logic [2:0] WORD_BYTES = 3'd4;

   // Number of RAM bytes a transaction moves; fetches are always a full word.
   function automatic logic [2:0] byte_count(input logic is_fetch, input logic [1:0] width);
      logic [2:0] n;
      if (is_fetch) begin
         n = WORD_BYTES;
      end else begin
         case (width)
            WIDTH_BYTE: n = 3'd1;
            WIDTH_HALF: n = 3'd2;
            default:    n = WORD_BYTES;
         endcase
      end
      return n;
   endfunction

   // Little-endian byte lane select.
   function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
      logic [31:0] shifted;
      shifted = word >> {idx, 3'b000};
      return shifted[7:0];
   endfunction

endpackage

// File: rtl/mem_arbiter_load_extend.sv
// load_extend
//   Combinational load result formatter. Keeps the low 1/2/4 bytes of the
//   assembled little-endian word and fills the unused upper bytes with zero,
//   or with the top loaded bit for signed byte/half loads.
// Ports
//   raw_in     [31:0]  assembled bytes (unused upper bytes don't care)
//   width_in   [1:0]   00 byte, 01 half, 10/11 word
//   signed_in          sign-extend byte/half loads
//   result_out [31:0]  formatted load result
module load_extend
   import mem_arbiter_pkg::*;
(
   input  logic [31:0] raw_in,
   input  logic [1:0]  width_in,
   input  logic        signed_in,
   output logic [31:0] result_out
);

   always_comb begin
      case (width_in)
         WIDTH_BYTE: result_out = {{24{signed_in & raw_in[7]}},  raw_in[7:0]};
         WIDTH_HALF: result_out = {{16{signed_in & raw_in[15]}}, raw_in[15:0]};
         default:    result_out = raw_in;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates an instruction-fetch port and a load/store data port onto a
//   byte-wide synchronous RAM (read data one cycle after address). The data
//   port has priority. Words are moved one byte per cycle, little-endian.
//   rdy_in low freezes the block; ram_wr_out is gated off while frozen.
// Ports
//   clk_in, rst_in (sync, active-low), rdy_in (global ready)
//   if_req_in/if_addr_in            fetch request;  if_done_out/if_inst_out result
//   mem_load_in/mem_store_in/mem_addr_in/mem_val_in/mem_width_in/mem_signed_in
//                                   data request;   mem_done_out/mem_data_out result
//   ram_a_out/ram_wr_out/ram_dout_out/ram_din_in   byte RAM port
//   busy_out                        high whenever the FSM is not idle
// Build option
//   MEM_ARB_FETCH_ABORT_EN adds if_flush_in, which abandons an in-progress
//   fetch read (back to idle, no done pulse).
//
// state    | meaning
// ST_IDLE  | sample requests, data port wins over fetch
// ST_READ  | present byte addresses, capture ram_din_in one cycle later
// ST_WRITE | one byte written per cycle
// ST_DONE  | one-cycle done pulse, result valid
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
`ifdef MEM_ARB_FETCH_ABORT_EN
   input  logic        if_flush_in,
`endif
   input  logic        if_req_in,
   input  logic [31:0] if_addr_in,
   output logic        if_done_out,
   output logic [31:0] if_inst_out,
   input  logic        mem_load_in,
   input  logic        mem_store_in,
   input  logic [31:0] mem_addr_in,
   input  logic [31:0] mem_val_in,
   input  logic [1:0]  mem_width_in,
   input  logic        mem_signed_in,
   output logic        mem_done_out,
   output logic [31:0] mem_data_out,
   output logic [31:0] ram_a_out,
   output logic        ram_wr_out,
   output logic [7:0]  ram_dout_out,
   input  logic [7:0]  ram_din_in,
   output logic        busy_out
);

   logic [1:0]  state_q,    state_d;
   logic [1:0]  cnt_q,      cnt_d;
   logic        valid_q,    valid_d;
   logic        resume_q,   resume_d;
   logic        is_fetch_q, is_fetch_d;
   logic [2:0]  nbytes_q,   nbytes_d;
   logic [1:0]  width_q,    width_d;
   logic        signed_q,   signed_d;
   logic [31:0] addr_q,     addr_d;
   logic [31:0] val_q,      val_d;
   logic [31:0] raw_q,      raw_d;
   logic [31:0] ram_a_q,    ram_a_d;
   logic        ram_wr_q,   ram_wr_d;
   logic [7:0]  ram_dout_q, ram_dout_d;
   logic        if_done_q,  if_done_d;
   logic        mem_done_q, mem_done_d;
   logic [31:0] if_inst_q,  if_inst_d;
   logic [31:0] mem_data_q, mem_data_d;
   logic        busy_q,     busy_d;

   logic [31:0] raw_cap;
   logic [31:0] ext_data;
   logic [2:0]  issued;
   logic        last_byte;
   logic        flush_req;

`ifdef MEM_ARB_FETCH_ABORT_EN
   assign flush_req = if_flush_in;
`else
   assign flush_req = 1'b0;
`endif

   // valid_q marks that ram_din_in holds the byte addressed last cycle.
   assign raw_cap   = raw_q | ({24'd0, ram_din_in} << {cnt_q, 3'b000});
   assign issued    = {1'b0, cnt_q} + {2'b00, valid_q} + 3'd1;
   assign last_byte = ({1'b0, cnt_q} == (nbytes_q - 3'd1));
   assign resume_d  = ~rdy_in;
   assign busy_d    = (state_d != ST_IDLE);

   load_extend u_load_extend (
      .raw_in     (raw_cap),
      .width_in   (width_q),
      .signed_in  (signed_q),
      .result_out (ext_data)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      valid_d    = valid_q;
      is_fetch_d = is_fetch_q;
      nbytes_d   = nbytes_q;
      width_d    = width_q;
      signed_d   = signed_q;
      addr_d     = addr_q;
      val_d      = val_q;
      raw_d      = raw_q;
      ram_a_d    = ram_a_q;
      ram_wr_d   = ram_wr_q;
      ram_dout_d = ram_dout_q;
      if_done_d  = if_done_q;
      mem_done_d = mem_done_q;
      if_inst_d  = if_inst_q;
      mem_data_d = mem_data_q;

      if (rdy_in) begin
         if_done_d  = 1'b0;
         mem_done_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               cnt_d   = 2'd0;
               valid_d = 1'b0;
               raw_d   = 32'd0;
               if (mem_load_in || mem_store_in) begin
                  is_fetch_d = 1'b0;
                  nbytes_d   = byte_count(1'b0, mem_width_in);
                  width_d    = mem_width_in;
                  signed_d   = mem_signed_in;
                  addr_d     = mem_addr_in;
                  val_d      = mem_val_in;
                  ram_a_d    = mem_addr_in;
                  if (mem_store_in) begin
                     state_d    = ST_WRITE;
                     ram_wr_d   = 1'b1;
                     ram_dout_d = mem_val_in[7:0];
                  end else begin
                     state_d = ST_READ;
                  end
               end else if (if_req_in) begin
                  is_fetch_d = 1'b1;
                  nbytes_d   = WORD_BYTES;
                  width_d    = WIDTH_WORD;
                  signed_d   = 1'b0;
                  addr_d     = if_addr_in;
                  ram_a_d    = if_addr_in;
                  state_d    = ST_READ;
               end
            end

            ST_READ: begin
               if (is_fetch_q && flush_req) begin
                  state_d = ST_IDLE;
                  cnt_d   = 2'd0;
                  valid_d = 1'b0;
               end else if (resume_q) begin
                  // The byte in flight before the freeze is lost; re-present
                  // its address and capture it a cycle later.
                  ram_a_d = addr_q + {30'd0, cnt_q};
                  valid_d = 1'b0;
               end else begin
                  valid_d = 1'b1;
                  if (issued < nbytes_q) begin
                     ram_a_d = ram_a_q + 32'd1;
                  end
                  if (valid_q) begin
                     raw_d = raw_cap;
                     if (last_byte) begin
                        state_d = ST_DONE;
                        cnt_d   = 2'd0;
                        valid_d = 1'b0;
                        if (is_fetch_q) begin
                           if_inst_d = raw_cap;
                           if_done_d = 1'b1;
                        end else begin
                           mem_data_d = ext_data;
                           mem_done_d = 1'b1;
                        end
                     end else begin
                        cnt_d = cnt_q + 2'd1;
                     end
                  end
               end
            end

            ST_WRITE: begin
               if (last_byte) begin
                  state_d    = ST_DONE;
                  cnt_d      = 2'd0;
                  ram_wr_d   = 1'b0;
                  mem_done_d = 1'b1;
               end else begin
                  cnt_d      = cnt_q + 2'd1;
                  ram_a_d    = ram_a_q + 32'd1;
                  ram_dout_d = get_byte(val_q, cnt_q + 2'd1);
               end
            end

            ST_DONE: begin
               state_d = ST_IDLE;
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 2'd0;
         valid_q    <= 1'b0;
         resume_q   <= 1'b0;
         is_fetch_q <= 1'b0;
         nbytes_q   <= 3'd0;
         width_q    <= 2'd0;
         signed_q   <= 1'b0;
         addr_q     <= 32'd0;
         val_q      <= 32'd0;
         raw_q      <= 32'd0;
         ram_a_q    <= 32'd0;
         ram_wr_q   <= 1'b0;
         ram_dout_q <= 8'd0;
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
         if_inst_q  <= 32'd0;
         mem_data_q <= 32'd0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         resume_q   <= resume_d;
         is_fetch_q <= is_fetch_d;
         nbytes_q   <= nbytes_d;
         width_q    <= width_d;
         signed_q   <= signed_d;
         addr_q     <= addr_d;
         val_q      <= val_d;
         raw_q      <= raw_d;
         ram_a_q    <= ram_a_d;
         ram_wr_q   <= ram_wr_d;
         ram_dout_q <= ram_dout_d;
         if_done_q  <= if_done_d;
         mem_done_q <= mem_done_d;
         if_inst_q  <= if_inst_d;
         mem_data_q <= mem_data_d;
         busy_q     <= busy_d;
      end
   end

   assign if_done_out  = if_done_q;
   assign if_inst_out  = if_inst_q;
   assign mem_done_out = mem_done_q;
   assign mem_data_out = mem_data_q;
   assign ram_a_out    = ram_a_q;
   // A frozen write must not reach the RAM; it is replayed on resume.
   assign ram_wr_out   = ram_wr_q & rdy_in;
   assign ram_dout_out = ram_dout_q;
   assign busy_out     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int K_FETCH = 0;
   localparam int K_LOAD  = 1;
   localparam int K_STORE = 2;
   localparam int K_BOTH  = 3;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic        if_req_in;
   logic [31:0] if_addr_in;
   logic        if_done_out;
   logic [31:0] if_inst_out;
   logic        mem_load_in, mem_store_in;
   logic [31:0] mem_addr_in, mem_val_in;
   logic [1:0]  mem_width_in;
   logic        mem_signed_in;
   logic        mem_done_out;
   logic [31:0] mem_data_out;
   logic [31:0] ram_a_out;
   logic        ram_wr_out;
   logic [7:0]  ram_dout_out;
   logic [7:0]  ram_din_in;
   logic        busy_out;
`ifdef MEM_ARB_FETCH_ABORT_EN
   logic        if_flush_in;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   mem_arbiter dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
`ifdef MEM_ARB_FETCH_ABORT_EN
      .if_flush_in   (if_flush_in),
`endif
      .if_req_in     (if_req_in),
      .if_addr_in    (if_addr_in),
      .if_done_out   (if_done_out),
      .if_inst_out   (if_inst_out),
      .mem_load_in   (mem_load_in),
      .mem_store_in  (mem_store_in),
      .mem_addr_in   (mem_addr_in),
      .mem_val_in    (mem_val_in),
      .mem_width_in  (mem_width_in),
      .mem_signed_in (mem_signed_in),
      .mem_done_out  (mem_done_out),
      .mem_data_out  (mem_data_out),
      .ram_a_out     (ram_a_out),
      .ram_wr_out    (ram_wr_out),
      .ram_dout_out  (ram_dout_out),
      .ram_din_in    (ram_din_in),
      .busy_out      (busy_out)
   );

   // Byte RAM model, 4 KiB aliased over the address space (wraps like the DUT).
   logic [7:0] ram [0:4095];

   always @(posedge clk_in) begin
      if (ram_wr_out) ram[ram_a_out[11:0]] <= ram_dout_out;
      ram_din_in <= ram[ram_a_out[11:0]];
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic int nbytes(input int kind, input logic [1:0] w);
      if (kind == K_FETCH) return 4;
      if (w == 2'b00) return 1;
      if (w == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [7:0] rd_byte(input logic [31:0] a);
      return ram[a[11:0]];
   endfunction

   // Expected load value from the RAM contents using plain arithmetic.
   function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input logic sgn);
      longint unsigned v;
      logic [31:0] ai;
      v = 0;
      for (int i = 0; i < n; i++) begin
         ai = a + 32'(i);
         v  = v + (longint'(rd_byte(ai)) << (8 * i));
      end
      if (sgn && n < 4 && v >= (64'd1 << (8 * n - 1)))
         v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
      return v[31:0];
   endfunction

   task automatic idle_inputs();
      if_req_in = 0; mem_load_in = 0; mem_store_in = 0;
`ifdef MEM_ARB_FETCH_ABORT_EN
      if_flush_in = 0;
`endif
   endtask

   task automatic run_txn(input string name, input int kind, input logic [31:0] addr,
                          input logic [1:0] width, input logic sgn, input logic [31:0] val,
                          input int frz_at, input int frz_len, input logic chk_lat,
                          input int exp_lat, input logic [31:0] exp_data);
      int n, lat, wr_cnt;
      logic [31:0] inst_before, data_before, wa;
      logic [7:0] beyond_before;
      logic is_fetch, is_store, d, other;
      n = nbytes(kind, width);
      is_fetch = (kind == K_FETCH);
      is_store = (kind == K_STORE || kind == K_BOTH);
      inst_before = if_inst_out;
      data_before = mem_data_out;
      wa = addr + 32'(n);
      beyond_before = rd_byte(wa);
      @(negedge clk_in);
      if (is_fetch) begin
         if_req_in = 1; if_addr_in = addr;
      end else begin
         mem_addr_in = addr; mem_width_in = width; mem_signed_in = sgn; mem_val_in = val;
         mem_load_in  = (kind == K_LOAD || kind == K_BOTH);
         mem_store_in = is_store;
      end
      lat = -1; wr_cnt = 0;
      for (int c = 1; c <= 60 && lat < 0; c++) begin
         @(negedge clk_in);
         if (frz_len > 0 && c == frz_at) rdy_in = 0;
         if (frz_len > 0 && c == frz_at + frz_len) rdy_in = 1;
         #1;
         if (!rdy_in) check({name, " wr_while_frozen"}, {31'd0, ram_wr_out}, 32'd0);
         if (ram_wr_out) begin
            wa = addr + 32'(wr_cnt);
            check({name, " wr_addr"}, ram_a_out, wa);
            check({name, " wr_data"}, {24'd0, ram_dout_out}, (val >> (8 * wr_cnt)) & 32'hFF);
            if (frz_len == 0) check({name, " wr_cycle"}, c, wr_cnt + 1);
            wr_cnt++;
         end
         d     = is_fetch ? if_done_out : mem_done_out;
         other = is_fetch ? mem_done_out : if_done_out;
         if (other) check({name, " wrong_done"}, {31'd0, other}, 32'd0);
         if (d) lat = c;
      end
      if (lat < 0) begin
         check({name, " done_timeout"}, 32'd0, 32'd1);
      end else begin
         check({name, " busy_at_done"}, {31'd0, busy_out}, 32'd1);
         idle_inputs();
         if (chk_lat) check({name, " latency"}, lat, exp_lat);
         if (is_fetch) begin
            check({name, " inst"}, if_inst_out, exp_data);
            check({name, " data_hold"}, mem_data_out, data_before);
         end else if (!is_store) begin
            check({name, " data"}, mem_data_out, exp_data);
            check({name, " inst_hold"}, if_inst_out, inst_before);
         end
         @(negedge clk_in); #1;
         check({name, " done_one_cycle"}, {30'd0, if_done_out, mem_done_out}, 32'd0);
         check({name, " busy_after"}, {31'd0, busy_out}, 32'd0);
         if (is_store) begin
            check({name, " wr_count"}, wr_cnt, n);
            for (int i = 0; i < n; i++) begin
               wa = addr + 32'(i);
               check({name, " ram_byte"}, {24'd0, rd_byte(wa)}, (val >> (8 * i)) & 32'hFF);
            end
            if (n < 4) begin
               wa = addr + 32'(n);
               check({name, " ram_untouched"}, {24'd0, rd_byte(wa)}, {24'd0, beyond_before});
            end
            check({name, " data_hold"}, mem_data_out, data_before);
         end
      end
      idle_inputs();
      rdy_in = 1;
   endtask

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [1:0]  width;
      logic        sgn;
      logic [31:0] val;
      int          lat;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int ld_at, if_at, pulses, n, kind, fa, fl, lat;
      logic [31:0] a, v, e;
      logic [1:0] w;
      logic s;

      for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
      ram[12'h100] = 8'h13; ram[12'h101] = 8'h05;
      ram[12'h200] = 8'h80;
      ram[12'h400] = 8'h34; ram[12'h401] = 8'hF2;
      ram[12'hFFE] = 8'h11; ram[12'hFFF] = 8'h22; ram[12'h000] = 8'h33; ram[12'h001] = 8'h44;

      rst_in = 0; rdy_in = 1; if_addr_in = 0; mem_addr_in = 0; mem_val_in = 0;
      mem_width_in = 0; mem_signed_in = 0;
      idle_inputs();
      repeat (3) @(negedge clk_in);
      #1;
      check("reset busy",     {31'd0, busy_out},     32'd0);
      check("reset if_done",  {31'd0, if_done_out},  32'd0);
      check("reset mem_done", {31'd0, mem_done_out}, 32'd0);
      check("reset ram_wr",   {31'd0, ram_wr_out},   32'd0);
      check("reset ram_a",    ram_a_out,             32'd0);
      check("reset if_inst",  if_inst_out,           32'd0);
      check("reset mem_data", mem_data_out,          32'd0);
      rst_in = 1;
      @(negedge clk_in);

      vecs.push_back('{K_FETCH, 32'h0000_0100, 2'b10, 1'b0, 32'h0,         6, 32'h0000_0513});
      vecs.push_back('{K_LOAD,  32'h0000_0200, 2'b00, 1'b1, 32'h0,         3, 32'hFFFF_FF80});
      vecs.push_back('{K_LOAD,  32'h0000_0200, 2'b00, 1'b0, 32'h0,         3, 32'h0000_0080});
      vecs.push_back('{K_STORE, 32'h0000_0300, 2'b10, 1'b0, 32'hDEAD_BEEF, 5, 32'h0});
      vecs.push_back('{K_LOAD,  32'h0000_0400, 2'b01, 1'b1, 32'h0,         4, 32'hFFFF_F234});
      vecs.push_back('{K_LOAD,  32'h0000_0400, 2'b01, 1'b0, 32'h0,         4, 32'h0000_F234});
      vecs.push_back('{K_LOAD,  32'hFFFF_FFFE, 2'b11, 1'b0, 32'h0,         6, 32'h4433_2211});
      vecs.push_back('{K_STORE, 32'hFFFF_FFFF, 2'b01, 1'b0, 32'h0000_A55A, 3, 32'h0});
      vecs.push_back('{K_BOTH,  32'h0000_0500, 2'b00, 1'b0, 32'h0000_0077, 2, 32'h0});
      vecs.push_back('{K_FETCH, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0,         6, 32'h0044_A55A});
      vecs.push_back('{K_LOAD,  32'h0000_0300, 2'b10, 1'b1, 32'h0,         6, 32'hDEAD_BEEF});

      foreach (vecs[i])
         run_txn($sformatf("vec%0d", i), vecs[i].kind, vecs[i].addr, vecs[i].width,
                 vecs[i].sgn, vecs[i].val, 0, 0, 1'b1, vecs[i].lat, vecs[i].exp);

      // Store frozen for three cycles starting at its second byte.
      run_txn("sw_freeze", K_STORE, 32'h0000_0600, 2'b10, 1'b0, 32'hCAFE_F00D, 2, 3, 1'b1, 8, 32'h0);

      // Simultaneous LH and fetch: load first, fetch granted right after.
      @(negedge clk_in);
      mem_addr_in = 32'h400; mem_width_in = 2'b01; mem_signed_in = 1; mem_load_in = 1;
      if_addr_in = 32'h100; if_req_in = 1;
      ld_at = -1; if_at = -1;
      for (int c = 1; c <= 40 && if_at < 0; c++) begin
         @(negedge clk_in); #1;
         if (mem_done_out && ld_at < 0) begin ld_at = c; mem_load_in = 0; end
         if (if_done_out) begin if_at = c; if_req_in = 0; end
      end
      check("arb load_done_cycle",  ld_at, 4);
      check("arb fetch_done_cycle", if_at, 11);
      check("arb load_data",        mem_data_out, 32'hFFFF_F234);
      check("arb fetch_inst",       if_inst_out,  32'h0000_0513);
      idle_inputs();
      repeat (2) @(negedge clk_in);

`ifdef MEM_ARB_FETCH_ABORT_EN
      @(negedge clk_in);
      if_addr_in = 32'h300; if_req_in = 1;
      @(negedge clk_in);
      @(negedge clk_in);
      if_flush_in = 1; if_req_in = 0;
      @(negedge clk_in); #1;
      check("flush busy", {31'd0, busy_out}, 32'd0);
      if_flush_in = 0;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_in); #1;
         if (if_done_out) pulses++;
      end
      check("flush no_done", pulses, 0);
      check("flush inst_hold", if_inst_out, 32'h0000_0513);
`endif

      // Reset while the fetch's third byte address is on the RAM port.
      @(negedge clk_in);
      if_addr_in = 32'h100; if_req_in = 1;
      repeat (3) @(negedge clk_in);
      rst_in = 0; if_req_in = 0;
      @(negedge clk_in); #1;
      check("rst busy",     {31'd0, busy_out},     32'd0);
      check("rst if_inst",  if_inst_out,           32'd0);
      check("rst mem_data", mem_data_out,          32'd0);
      check("rst ram_a",    ram_a_out,             32'd0);
      check("rst ram_dout", {24'd0, ram_dout_out}, 32'd0);
      check("rst dones",    {30'd0, if_done_out, mem_done_out}, 32'd0);
      rst_in = 1;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_in); #1;
         if (if_done_out || mem_done_out || busy_out) pulses++;
      end
      check("rst no_activity", pulses, 0);

      // Randomized transactions against the arithmetic model.
      for (int t = 0; t < 40; t++) begin
         kind = int'($urandom_range(0, 3));
         a = $urandom();
         if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
         w = 2'($urandom_range(0, 3));
         s = 1'($urandom_range(0, 1));
         v = $urandom();
         n = nbytes(kind, w);
         fa = 0; fl = 0;
         if ($urandom_range(0, 2) == 0) begin
            fa = int'($urandom_range(1, n));
            fl = int'($urandom_range(1, 3));
         end
         if (kind == K_FETCH || kind == K_LOAD) begin
            for (int i = 0; i < 4; i++) ram[12'(a + 32'(i))] = 8'($urandom());
         end
         e = model_load(a, n, (kind == K_LOAD) ? s : 1'b0);
         if (kind == K_STORE || kind == K_BOTH) lat = n + 1 + fl;
         else lat = n + 2;
         run_txn($sformatf("rnd%0d", t), kind, a, w, s, v, fa, fl,
                 (kind == K_STORE || kind == K_BOTH || fl == 0), lat, e);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
